// File: rtl/mf_pkg.sv
// Shared constants for the Multiface NMI cartridge: shadow RAM offsets,
// write-only port prefixes and NMI vector addresses.
package mf_pkg;

    localparam logic [12:0] OFF_GA_PEN    = 13'h1FCF;
    localparam logic [12:0] OFF_GA_BORDER = 13'h1FDF;
    localparam logic [12:0] OFF_GA_INK    = 13'h1F90;
    localparam logic [12:0] OFF_GA_MODE   = 13'h1FEF;
    localparam logic [12:0] OFF_GA_RAMCFG = 13'h1FFF;
    localparam logic [12:0] OFF_CRTC_SEL  = 13'h1CFF;
    localparam logic [12:0] OFF_CRTC_DATA = 13'h1DB0;
    localparam logic [12:0] OFF_PPI_CTRL  = 13'h17FF;
    localparam logic [12:0] OFF_ROM_SEL   = 13'h1AAC;

    localparam logic [7:0] PFX_GA        = 8'h7F;
    localparam logic [7:0] PFX_CRTC_SEL  = 8'hBC;
    localparam logic [7:0] PFX_CRTC_DATA = 8'hBD;
    localparam logic [7:0] PFX_PPI       = 8'hF7;
    localparam logic [7:0] PFX_ROM       = 8'hDF;

    localparam logic [15:0] VEC_NMI  = 16'h0066;
    localparam logic [15:0] VEC_HIDE = 16'h0065;

    // Gate-array command class carried in io_dout[7:6]
    typedef enum logic [1:0] {
        GA_PEN    = 2'b00,
        GA_INK    = 2'b01,
        GA_MODE   = 2'b10,
        GA_RAMCFG = 2'b11
    } ga_cmd_e;

endpackage

// File: rtl/mf_shadow_decode.sv
// Maps an I/O write port (high address byte) and command to the shadow RAM
// offset in the last cartridge page, plus pen/CRTC register latch strobes.
module mf_shadow_decode
    import mf_pkg::*;
#(
    parameter int unsigned CRTC_REGS = 16
) (
    input  logic [7:0]  port_hi,
    input  ga_cmd_e     ga_cmd,
    input  logic [4:0]  pen_index,
    input  logic [4:0]  crtc_reg,
    output logic        store,
    output logic [12:0] off,
    output logic        pen_we,
    output logic        crtc_we
);

    always_comb begin
        store   = 1'b0;
        off     = '0;
        pen_we  = 1'b0;
        crtc_we = 1'b0;
        case (port_hi)
            PFX_GA: begin
                store = 1'b1;
                case (ga_cmd)
                    GA_PEN: begin
                        off    = OFF_GA_PEN;
                        pen_we = 1'b1;
                    end
                    GA_INK:  off = pen_index[4] ? OFF_GA_BORDER
                                                : OFF_GA_INK + {9'd0, pen_index[3:0]};
                    GA_MODE: off = OFF_GA_MODE;
                    default: off = OFF_GA_RAMCFG;
                endcase
            end
            PFX_CRTC_SEL: begin
                store   = 1'b1;
                off     = OFF_CRTC_SEL;
                crtc_we = 1'b1;
            end
            PFX_CRTC_DATA: begin
                // Registers beyond the shadowed set have no slot and are dropped
                if ({27'd0, crtc_reg} < CRTC_REGS) begin
                    store = 1'b1;
                    off   = OFF_CRTC_DATA + {8'd0, crtc_reg};
                end
            end
            PFX_PPI: begin
                store = 1'b1;
                off   = OFF_PPI_CTRL;
            end
            PFX_ROM: begin
                store = 1'b1;
                off   = OFF_ROM_SEL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mf_nmi_ctrl.sv
// Multiface-class NMI cartridge controller: freeze-to-NMI arbitration, ROM/RAM
// paging at the NMI vector, hide/unhide ports and write-only register shadowing.
module mf_nmi_ctrl
    import mf_pkg::*;
#(
    parameter int unsigned RAM_AW    = 13,
    parameter int unsigned CRTC_REGS = 16,
    parameter logic [15:0] CTRL_PORT = 16'hFEE8,
    parameter logic [15:0] PAGE_PORT = 16'hFEEC
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        soft_reset,
    input  logic        key_nmi,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_m1,
    input  logic        io_wr,
    input  logic [7:0]  io_dout,
    input  logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic        nmi,
    output logic        mf_en,
    output logic        mf_hidden,
    output logic        rom_sel,
    output logic        ram_sel,
    output logic [7:0]  ram_dout
);

    localparam int unsigned PAGE_W    = (RAM_AW > 13) ? RAM_AW - 13 : 1;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    logic              io_wr_q, m1_q, key_q;
    logic              nmi_q, nmi_d;
    logic              mf_en_q, mf_en_d;
    logic              hidden_q, hidden_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [4:0]        pen_q, pen_d;
    logic [4:0]        crtc_q, crtc_d;
    logic              st_pend_q, st_pend_d;
    logic [RAM_AW-1:0] st_addr_q, st_addr_d;
    logic [7:0]        st_data_q, st_data_d;
    logic              buf_valid_q, buf_valid_d;
    logic [RAM_AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic [7:0]        mem_q [RAM_DEPTH];

    logic              io_rise, m1_rise, key_rise;
    logic              ctrl_hit, page_hit, vec_hit, hide_hit, arm_hit, sh_go, cpu_wr;
    logic              dec_store, dec_pen_we, dec_crtc_we;
    logic [12:0]       dec_off;
    logic [RAM_AW-1:0] cpu_ram_addr, sh_addr;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    assign io_rise  = io_wr & ~io_wr_q;
    assign m1_rise  = cpu_m1 & ~m1_q;
    assign key_rise = key_nmi & ~key_q;

    assign ctrl_hit = io_rise && (cpu_addr[15:2] == CTRL_PORT[15:2]);
    assign page_hit = io_rise && (cpu_addr[15:2] == PAGE_PORT[15:2]);
    assign vec_hit  = m1_rise && (cpu_addr == VEC_NMI) && nmi_q;
    assign hide_hit = m1_rise && (cpu_addr == VEC_HIDE) && mf_en_q;
    assign arm_hit  = key_rise & ~mf_en_q;
    assign sh_go    = io_rise & dec_store & ~ctrl_hit & ~page_hit;

    assign rom_sel = mf_en_q && (cpu_addr[15:13] == 3'b000);
    assign ram_sel = mf_en_q && (cpu_addr[15:13] == 3'b001);
    assign cpu_wr  = mem_wr & ram_sel;

    // Single-page builds drop the page bit through truncation
    assign cpu_ram_addr = RAM_AW'({page_q, cpu_addr[12:0]});
    assign sh_addr      = RAM_AW'({{PAGE_W{1'b1}}, dec_off});

    mf_shadow_decode #(
        .CRTC_REGS (CRTC_REGS)
    ) u_decode (
        .port_hi   (cpu_addr[15:8]),
        .ga_cmd    (ga_cmd_e'(io_dout[7:6])),
        .pen_index (pen_q),
        .crtc_reg  (crtc_q),
        .store     (dec_store),
        .off       (dec_off),
        .pen_we    (dec_pen_we),
        .crtc_we   (dec_crtc_we)
    );

    always_comb begin
        nmi_d       = nmi_q;
        mf_en_d     = mf_en_q;
        hidden_d    = hidden_q;
        page_d      = page_q;
        pen_d       = pen_q;
        crtc_d      = crtc_q;
        st_pend_d   = sh_go;
        st_addr_d   = sh_go ? sh_addr : st_addr_q;
        st_data_d   = sh_go ? io_dout : st_data_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        ram_we      = 1'b0;
        ram_waddr   = st_addr_q;
        ram_wdata   = st_data_q;
        ram_dout_d  = mem_q[cpu_ram_addr];

        if (arm_hit) nmi_d = 1'b1;
        if (page_hit) page_d = (RAM_AW > 13) ? PAGE_W'(io_dout) : '0;
        if (ctrl_hit) mf_en_d = ~cpu_addr[1] & ~hidden_q;
        if (hide_hit) hidden_d = 1'b1;
        if (vec_hit) begin
            mf_en_d  = 1'b1;
            hidden_d = 1'b0;
            nmi_d    = 1'b0;
            page_d   = '0;
        end
        if (sh_go && dec_pen_we) pen_d = io_dout[4:0];
        if (sh_go && dec_crtc_we) crtc_d = io_dout[4:0];

        // Single write port: pending shadow, then held CPU byte, then live CPU write
        if (st_pend_q) begin
            ram_we = 1'b1;
            if (cpu_wr) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = cpu_ram_addr;
                buf_data_d  = mem_din;
            end
        end else if (buf_valid_q) begin
            ram_we      = 1'b1;
            ram_waddr   = buf_addr_q;
            ram_wdata   = buf_data_q;
            buf_valid_d = cpu_wr;
            if (cpu_wr) begin
                buf_addr_d = cpu_ram_addr;
                buf_data_d = mem_din;
            end
        end else if (cpu_wr) begin
            ram_we    = 1'b1;
            ram_waddr = cpu_ram_addr;
            ram_wdata = mem_din;
        end

        if (soft_reset) begin
            nmi_d       = 1'b0;
            mf_en_d     = 1'b0;
            hidden_d    = 1'b0;
            page_d      = '0;
            pen_d       = '0;
            crtc_d      = '0;
            st_pend_d   = 1'b0;
            buf_valid_d = 1'b0;
            ram_we      = 1'b0;
            ram_dout_d  = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io_wr_q     <= 1'b0;
            m1_q        <= 1'b0;
            key_q       <= 1'b0;
            nmi_q       <= 1'b0;
            mf_en_q     <= 1'b0;
            hidden_q    <= 1'b0;
            page_q      <= '0;
            pen_q       <= '0;
            crtc_q      <= '0;
            st_pend_q   <= 1'b0;
            st_addr_q   <= '0;
            st_data_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            ram_dout_q  <= '0;
        end else begin
            io_wr_q     <= io_wr;
            m1_q        <= cpu_m1;
            key_q       <= key_nmi;
            nmi_q       <= nmi_d;
            mf_en_q     <= mf_en_d;
            hidden_q    <= hidden_d;
            page_q      <= page_d;
            pen_q       <= pen_d;
            crtc_q      <= crtc_d;
            st_pend_q   <= st_pend_d;
            st_addr_q   <= st_addr_d;
            st_data_q   <= st_data_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    end

    assign nmi       = nmi_q;
    assign mf_en     = mf_en_q;
    assign mf_hidden = hidden_q;
    assign ram_dout  = ram_dout_q;

endmodule
